// File: rtl/dp_defs_pkg.sv
// Shared definitions for the datapath executor: widths, opcodes, instruction
// field positions, FSM state encoding and screen geometry.
// Optional feature macro: DP_CLEAR_SCREEN_EN (adds the CLEAR state).
package dp_defs_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned OP_W    = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    // Instruction field positions
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned ADDR_LSB = 3;
    localparam int unsigned DATA_LSB = 11;
    localparam int unsigned X_LSB    = 3;
    localparam int unsigned Y_LSB    = 11;
    localparam int unsigned COL_LSB  = 18;
    localparam int unsigned PLOT_BIT = 21;
    // Bits [31:27] carry nothing, so only the low part is latched
    localparam int unsigned INSTR_USED_W = 27;

    localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
    localparam logic [OP_W-1:0] OP_MEMREAD  = 3'd1;
    localparam logic [OP_W-1:0] OP_MEMWRITE = 3'd2;
    localparam logic [OP_W-1:0] OP_DRAW     = 3'd3;
    localparam logic [OP_W-1:0] OP_CLEAR    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_DONE     = 3'd3
`ifdef DP_CLEAR_SCREEN_EN
        ,S_CLEAR   = 3'd4
`endif
    } state_t;

    // Decoded view of a latched instruction; fields overlap in the raw word
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [COL_W-1:0]  colour;
        logic              plot;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_USED_W-1:0] w);
        instr_t d;
        d.op     = w[OP_LSB   +: OP_W];
        d.addr   = w[ADDR_LSB +: ADDR_W];
        d.data   = w[DATA_LSB +: DATA_W];
        d.x      = w[X_LSB    +: X_W];
        d.y      = w[Y_LSB    +: Y_W];
        d.colour = w[COL_LSB  +: COL_W];
        d.plot   = w[PLOT_BIT];
        return d;
    endfunction

endpackage

// File: rtl/datapath_executor_if.sv
// Datapath instruction handshake plus VGA pixel port.
// master: initiator (drives start/instruction); slave: executor.
interface datapath_executor_if;
    import dp_defs_pkg::*;

    logic               start;
    logic [INSTR_W-1:0] instruction;
    logic               finished;
    logic [DATA_W-1:0]  result;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [COL_W-1:0]   vga_colour;
    logic               vga_plot;

    modport master (
        output start, instruction,
        input  finished, result, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, instruction,
        output finished, result, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/dp_ram.sv
// Single-port synchronous game-state RAM, one-cycle read latency, no reset.
// Ports: clock, i_we (write enable), i_addr, i_wdata, o_rdata (registered).
module dp_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/datapath_executor.sv
// Responder end of the datapath instruction handshake. Accepts one
// instruction per start pulse, executes it on the game-state RAM or the VGA
// pixel port, then raises finished with the result.
// Ports: clock, reset (async, active-high), bus (datapath_executor_if.slave).
// Optional feature macro: DP_CLEAR_SCREEN_EN (opcode 4 sweeps the screen).
module datapath_executor
    import dp_defs_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    datapath_executor_if.slave bus
);
    state_t                  r_state, w_state_nxt;
    logic                    r_armed, w_armed_nxt;
    logic [INSTR_USED_W-1:0] r_instr, w_instr_nxt;
    logic                    r_finished, w_finished_nxt;
    logic [DATA_W-1:0]       r_result, w_result_nxt;
    logic [X_W-1:0]          r_vga_x, w_vga_x_nxt;
    logic [Y_W-1:0]          r_vga_y, w_vga_y_nxt;
    logic [COL_W-1:0]        r_vga_colour, w_vga_colour_nxt;
    logic                    r_vga_plot, w_vga_plot_nxt;
`ifdef DP_CLEAR_SCREEN_EN
    logic [X_W-1:0]          r_clr_x, w_clr_x_nxt;
    logic [Y_W-1:0]          r_clr_y, w_clr_y_nxt;
`endif

    instr_t            w_dec;
    logic              w_accept;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_dec    = decode_instr(r_instr);
    // armed guarantees a held start pulse is taken only once
    assign w_accept = (r_state == S_IDLE) && bus.start && r_armed;
    assign w_ram_we = (r_state == S_EXEC) && (w_dec.op == OP_MEMWRITE);

    dp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_ram_we),
        .i_addr  (w_dec.addr),
        .i_wdata (w_dec.data),
        .o_rdata (w_ram_rdata)
    );

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_instr      <= '0;
            r_finished   <= 1'b1;
            r_result     <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
`ifdef DP_CLEAR_SCREEN_EN
            r_clr_x      <= '0;
            r_clr_y      <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_armed      <= w_armed_nxt;
            r_instr      <= w_instr_nxt;
            r_finished   <= w_finished_nxt;
            r_result     <= w_result_nxt;
            r_vga_x      <= w_vga_x_nxt;
            r_vga_y      <= w_vga_y_nxt;
            r_vga_colour <= w_vga_colour_nxt;
            r_vga_plot   <= w_vga_plot_nxt;
`ifdef DP_CLEAR_SCREEN_EN
            r_clr_x      <= w_clr_x_nxt;
            r_clr_y      <= w_clr_y_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_armed_nxt      = r_armed;
        w_instr_nxt      = r_instr;
        w_finished_nxt   = r_finished;
        w_result_nxt     = r_result;
        w_vga_x_nxt      = r_vga_x;
        w_vga_y_nxt      = r_vga_y;
        w_vga_colour_nxt = r_vga_colour;
        w_vga_plot_nxt   = 1'b0;
`ifdef DP_CLEAR_SCREEN_EN
        w_clr_x_nxt      = r_clr_x;
        w_clr_y_nxt      = r_clr_y;
`endif

        if (!bus.start) begin
            w_armed_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_instr_nxt    = bus.instruction[INSTR_USED_W-1:0];
                    w_finished_nxt = 1'b0;
                    w_armed_nxt    = 1'b0;
                    w_state_nxt    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_DONE;
                case (w_dec.op)
                    OP_MEMREAD: begin
                        w_state_nxt = S_MEM_WAIT;
                    end
                    OP_MEMWRITE: begin
                        w_result_nxt = w_dec.data;
                    end
                    OP_DRAW: begin
                        w_vga_x_nxt      = w_dec.x;
                        w_vga_y_nxt      = w_dec.y;
                        w_vga_colour_nxt = w_dec.colour;
                        w_vga_plot_nxt   = w_dec.plot;
                        w_result_nxt     = '0;
                    end
`ifdef DP_CLEAR_SCREEN_EN
                    OP_CLEAR: begin
                        w_clr_x_nxt = '0;
                        w_clr_y_nxt = '0;
                        w_state_nxt = S_CLEAR;
                    end
`endif
                    default: begin
                        w_result_nxt = '0;
                    end
                endcase
            end
            S_MEM_WAIT: begin
                w_result_nxt = w_ram_rdata;
                w_state_nxt  = S_DONE;
            end
            S_DONE: begin
                w_finished_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
`ifdef DP_CLEAR_SCREEN_EN
            // One pixel per cycle, x inner loop, y outer loop
            S_CLEAR: begin
                w_vga_x_nxt      = r_clr_x;
                w_vga_y_nxt      = r_clr_y;
                w_vga_colour_nxt = w_dec.colour;
                w_vga_plot_nxt   = 1'b1;
                if (r_clr_x == X_W'(SCREEN_W - 1)) begin
                    w_clr_x_nxt = '0;
                    if (r_clr_y == Y_W'(SCREEN_H - 1)) begin
                        w_result_nxt = '0;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_clr_y_nxt = r_clr_y + Y_W'(1);
                    end
                end else begin
                    w_clr_x_nxt = r_clr_x + X_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.finished   = r_finished;
    assign bus.result     = r_result;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
endmodule
